mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one external memory port between the instruction-fetch requester (IF stage) and the data-access requester (MEM stage) of the pipelined core.
- Grants one requester at a time and holds the memory request stable until the memory acknowledges.
- Returns read data and a one-cycle ready pulse to the owner; requesters use ~ready as their stall.
- Round-robin arbitration when both requesters contend; a watchdog aborts transactions the memory never acknowledges.

Parameters:
LENGTH, 32, address/data width
TIMEOUT, 255, max cycles waiting for mem_ack before abort (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
if_req  in  1  instruction read request
if_addr  in  LENGTH  instruction address
if_rdata  out  LENGTH  instruction read data
if_ready  out  1  instruction transfer done (1-cycle pulse)
dm_req  in  1  data request
dm_we  in  1  data write enable (1 = write)
dm_addr  in  LENGTH  data address
dm_wdata  in  LENGTH  data write value
dm_rdata  out  LENGTH  data read value
dm_ready  out  1  data transfer done (1-cycle pulse)
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_addr  out  LENGTH  memory address
mem_wdata  out  LENGTH  memory write data
mem_rdata  in  LENGTH  memory read data, valid with mem_ack
mem_ack  in  1  memory transfer complete
grant_d  out  1  1 = data side owns port (valid while busy)
busy  out  1  transaction outstanding
err  out  1  sticky timeout flag

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0: mem_*, x_rdata, x_ready, grant_d, busy, err. last_grant = I, wait counter = 0.
- States: IDLE, SERVE_I, SERVE_D. All outputs are registered.
- Requester contract:
  - Hold req, addr, we and wdata stable from assertion until the cycle x_ready=1.
  - Req may drop or re-assert the cycle after ready.
  - Fields are sampled only at the grant edge; changes after grant are ignored.
  - Dropping req early does not cancel a granted transaction; it completes and ready still pulses.
- Arbitration, evaluated in IDLE or in an ack cycle:
  - Only one requester eligible: grant it.
  - Both eligible: grant the one not equal to last_grant. After reset last_grant = I, so D wins the first tie.
  - On grant, latch fields into mem_addr/mem_we/mem_wdata. IF grants force mem_we=0 and mem_wdata=0. Set mem_req=1, busy=1, grant_d, last_grant; clear the counter.
- SERVE_x:
  - mem_req and fields held constant until mem_ack.
  - On mem_ack: capture mem_rdata into x_rdata (writes capture too). Next cycle x_ready=1 for exactly one cycle; x_rdata holds until the next completion for that side.
  - In the same ack cycle, arbitrate with the just-served requester excluded (its req is still high).
    - Other side requesting: go straight to SERVE_other; mem_req stays 1 (back-to-back, no bubble).
    - Otherwise: mem_req=0, busy=0, go to IDLE.
- Latency: zero-wait memory (ack in the first mem_req cycle) gives req at cycle 0, mem_req at cycle 1, x_ready at cycle 2. Each extra wait cycle adds 1.
- Watchdog:
  - Counter increments each SERVE cycle with mem_ack=0.
  - When the count reaches TIMEOUT with no ack: mem_req=0, err=1 (sticky until reset), x_rdata=0, x_ready pulses next cycle, state IDLE.
  - mem_ack in the same cycle the limit is reached wins: normal completion, no err.
- mem_ack while in IDLE is ignored.
- Reset mid-transaction aborts immediately: no ready pulse, mem_req=0.
- Counter width: clog2(TIMEOUT+1); no wrap.

Test Plan:
- Single fetch: if_req=1, if_addr=0x00000040; mem_ack=1 on the first mem_req cycle with mem_rdata=0x8C220004 -> mem_req high cycle 1, mem_we=0; if_ready=1 cycle 2 only; if_rdata=0x8C220004.
- Data write with 3 wait states: dm_req=1, dm_we=1, dm_addr=0x100, dm_wdata=0xCAFEBABE -> mem_req held 4 cycles with fields stable; dm_ready one pulse after ack; grant_d=1 throughout.
- Contention after reset: if_req and dm_req both high in cycle 0 with zero-wait memory -> D granted first, then I back-to-back (mem_req never drops); dm_ready cycle 2, if_ready cycle 3.
- Round-robin: both requesters held continuously for 6 transactions -> grants alternate D,I,D,I,D,I; neither side starves.
- Timeout: TIMEOUT=4, dm_req read, mem_ack never asserted -> mem_req drops after 4 wait cycles; err=1 and stays; dm_ready pulses with dm_rdata=0. A following if_req is served normally.
- Async reset mid-SERVE_D (rst=0 between clock edges) -> all outputs 0 immediately, no dm_ready pulse; after rst=1 the port is IDLE and last_grant=I.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the shared memory port.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_port_arbiter_if #(
  parameter int LENGTH = 32
);
  logic              if_req;
  logic [LENGTH-1:0] if_addr;
  logic [LENGTH-1:0] if_rdata;
  logic              if_ready;
  logic              dm_req;
  logic              dm_we;
  logic [LENGTH-1:0] dm_addr;
  logic [LENGTH-1:0] dm_wdata;
  logic [LENGTH-1:0] dm_rdata;
  logic              dm_ready;
  logic              mem_req;
  logic              mem_we;
  logic [LENGTH-1:0] mem_addr;
  logic [LENGTH-1:0] mem_wdata;
  logic [LENGTH-1:0] mem_rdata;
  logic              mem_ack;
  logic              grant_d;
  logic              busy;
  logic              err;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ready, dm_rdata, dm_ready,
    output mem_req, mem_we, mem_addr, mem_wdata, grant_d, busy, err
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ready, dm_rdata, dm_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata, grant_d, busy, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access,
// with back-to-back hand-over on ack and a watchdog that aborts unacknowledged transfers.
module mem_port_arbiter #(
  parameter int LENGTH  = 32,
  parameter int TIMEOUT = 255
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t          state_r;
  logic            last_d_r;
  logic [CW-1:0]   cnt_r;
  logic            start_s;
  logic            start_d_s;
  logic            done_s;
  logic            abort_s;

  // Decide completion/abort of the current owner and who (if anyone) starts next
  always_comb begin
    start_s   = 1'b0;
    start_d_s = 1'b0;
    done_s    = 1'b0;
    abort_s   = 1'b0;
    case (state_r)
      IDLE: begin
        start_s   = bus.if_req | bus.dm_req;
        start_d_s = bus.dm_req & (~bus.if_req | ~last_d_r);
      end
      SERVE_I: begin
        // the just-served side is excluded, so only the data side can follow
        done_s    = bus.mem_ack;
        abort_s   = ~bus.mem_ack & (cnt_r == LIMIT);
        start_s   = bus.mem_ack & bus.dm_req;
        start_d_s = 1'b1;
      end
      SERVE_D: begin
        done_s    = bus.mem_ack;
        abort_s   = ~bus.mem_ack & (cnt_r == LIMIT);
        start_s   = bus.mem_ack & bus.if_req;
        start_d_s = 1'b0;
      end
      default: begin
        start_s   = 1'b0;
        start_d_s = 1'b0;
      end
    endcase
  end

  // Ownership FSM with registered memory request, read data, ready pulses and error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= IDLE;
      last_d_r      <= 1'b0;
      cnt_r         <= {CW{1'b0}};
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= {LENGTH{1'b0}};
      bus.mem_wdata <= {LENGTH{1'b0}};
      bus.if_rdata  <= {LENGTH{1'b0}};
      bus.if_ready  <= 1'b0;
      bus.dm_rdata  <= {LENGTH{1'b0}};
      bus.dm_ready  <= 1'b0;
      bus.grant_d   <= 1'b0;
      bus.busy      <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      bus.if_ready <= 1'b0;
      bus.dm_ready <= 1'b0;
      if (done_s || abort_s) begin
        if (state_r == SERVE_D) begin
          bus.dm_rdata <= done_s ? bus.mem_rdata : {LENGTH{1'b0}};
          bus.dm_ready <= 1'b1;
        end else begin
          bus.if_rdata <= done_s ? bus.mem_rdata : {LENGTH{1'b0}};
          bus.if_ready <= 1'b1;
        end
      end
      if (abort_s) begin
        bus.err <= 1'b1;
      end
      if (start_s) begin
        state_r       <= start_d_s ? SERVE_D : SERVE_I;
        last_d_r      <= start_d_s;
        cnt_r         <= {CW{1'b0}};
        bus.mem_req   <= 1'b1;
        bus.busy      <= 1'b1;
        bus.grant_d   <= start_d_s;
        bus.mem_addr  <= start_d_s ? bus.dm_addr : bus.if_addr;
        bus.mem_we    <= start_d_s & bus.dm_we;
        bus.mem_wdata <= start_d_s ? bus.dm_wdata : {LENGTH{1'b0}};
      end else if (done_s || abort_s) begin
        state_r     <= IDLE;
        bus.mem_req <= 1'b0;
        bus.busy    <= 1'b0;
      end else if (state_r != IDLE) begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end
endmodule
